// File: rtl/rgbled_cycle_multi.sv
// ---------------------------------------------------------------------------
// rgbled_cycle_multi
// Parametrised N-channel LED breathing engine. Each channel walks a
// four-phase brightness envelope (UP, HIGH, DOWN, LOW) at its own speed.
// The resulting level is compared against one shared free-running PWM counter
// to produce a registered, active-high LED drive bit per channel.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   speed    per-channel speed, channel i in [i*SPEED_BITS +: SPEED_BITS]
//   enable   per-channel run/output enable (0 freezes the channel state)
//   sync     one-clock pulse reloading every channel to its start state
//   led_out  registered PWM outputs, one bit per channel
//
// Build option:
//   RGBLED_CYCLE_GAMMA_EN  square-law duty ((level*level) >> PWM_BITS) through
//                          one extra pipeline register; default is duty = level.
// ---------------------------------------------------------------------------
module rgbled_cycle_multi #(
    parameter int NCH        = 3,
    parameter int PWM_BITS   = 8,
    parameter int SPEED_BITS = 5,
    parameter int PRESC_BITS = 10,
    parameter int HOLD_STEPS = 64,
    parameter logic [2*NCH-1:0] START_PHASE = 6'b11_01_00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH*SPEED_BITS-1:0] speed,
    input  logic [NCH-1:0]            enable,
    input  logic                      sync,
    output logic [NCH-1:0]            led_out
);

    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        UP   = 2'd0,
        HIGH = 2'd1,
        DOWN = 2'd2,
        LOW  = 2'd3
    } phase_t;

    phase_t              phase [NCH];
    logic [PWM_BITS-1:0] level [NCH];
    logic [HOLD_W-1:0]   hold  [NCH];
    logic [SPEED_BITS-1:0] div [NCH];
    logic [PWM_BITS-1:0] duty  [NCH];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                strobe;

    function automatic phase_t start_of(input int ch);
        return phase_t'(START_PHASE[2*ch +: 2]);
    endfunction

    // Global step strobe: fires when the prescaler wraps, or every clock
    // when the prescaler has zero width.
    generate
        if (PRESC_BITS == 0) begin : g_no_presc
            assign strobe = 1'b1;
        end else begin : g_presc
            logic [PRESC_BITS-1:0] presc;
            always_ff @(posedge clk) begin
                if (rst || sync) begin
                    presc <= '0;
                end else begin
                    presc <= presc + PRESC_BITS'(1);
                end
            end
            assign strobe = &presc;
        end
    endgenerate

`ifdef RGBLED_CYCLE_GAMMA_EN
    // Square-law duty through a register; this stage adds one clock between
    // level and led_out but leaves the enable gating path untouched.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst || sync) begin
                duty[i] <= '0;
            end else begin
                duty[i] <= PWM_BITS'(({{PWM_BITS{1'b0}}, level[i]} *
                                      {{PWM_BITS{1'b0}}, level[i]}) >> PWM_BITS);
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            duty[i] = level[i];
        end
    end
`endif

    // Envelope FSMs, step dividers, shared PWM counter and output stage.
    // A disabled channel keeps div/phase/level/hold untouched so it resumes
    // exactly where it stopped; its output drops on the next clock.
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            pwm_cnt <= '0;
            led_out <= '0;
            for (int i = 0; i < NCH; i++) begin
                phase[i] <= start_of(i);
                level[i] <= (start_of(i) == HIGH || start_of(i) == DOWN) ? MAX_LEVEL : '0;
                hold[i]  <= '0;
                div[i]   <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            for (int i = 0; i < NCH; i++) begin
                led_out[i] <= enable[i] & (duty[i] > pwm_cnt);
                if (strobe && enable[i]) begin
                    // ">=" so a speed lowered below the running count steps at once.
                    if (div[i] >= speed[i*SPEED_BITS +: SPEED_BITS]) begin
                        div[i] <= '0;
                        unique case (phase[i])
                            UP: begin
                                if (level[i] == MAX_LEVEL) begin
                                    phase[i] <= HIGH;
                                    hold[i]  <= '0;
                                end else begin
                                    level[i] <= level[i] + PWM_BITS'(1);
                                end
                            end
                            HIGH: begin
                                if (hold[i] == HOLD_LAST) begin
                                    phase[i] <= DOWN;
                                end else begin
                                    hold[i] <= hold[i] + HOLD_W'(1);
                                end
                            end
                            DOWN: begin
                                if (level[i] == '0) begin
                                    phase[i] <= LOW;
                                    hold[i]  <= '0;
                                end else begin
                                    level[i] <= level[i] - PWM_BITS'(1);
                                end
                            end
                            LOW: begin
                                if (hold[i] == HOLD_LAST) begin
                                    phase[i] <= UP;
                                end else begin
                                    hold[i] <= hold[i] + HOLD_W'(1);
                                end
                            end
                            default: phase[i] <= UP;
                        endcase
                    end else begin
                        div[i] <= div[i] + SPEED_BITS'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rgbled_cycle_multi.sv
// ---------------------------------------------------------------------------
// tb_rgbled_cycle_multi
// Directed bench for rgbled_cycle_multi configured with NCH=3, PWM_BITS=4,
// SPEED_BITS=5, PRESC_BITS=0, HOLD_STEPS=4. Expected values are hand-derived
// from the envelope rules; duty expectations follow the build option
// RGBLED_CYCLE_GAMMA_EN.
// ---------------------------------------------------------------------------
module tb_rgbled_cycle_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] speed;
    logic [2:0]  enable;
    logic        sync;
    logic [2:0]  led_out;

    int checks = 0;
    int errors = 0;
    int cnt;

    rgbled_cycle_multi #(
        .NCH        (3),
        .PWM_BITS   (4),
        .SPEED_BITS (5),
        .PRESC_BITS (0),
        .HOLD_STEPS (4),
        .START_PHASE(6'b11_01_00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .speed   (speed),
        .enable  (enable),
        .sync    (sync),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; always returns on a falling edge so inputs
    // change and outputs are sampled away from the active edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reset held for three clocks with all channels disabled.
    task automatic applyStimulus(input logic [14:0] spd);
        rst    = 1'b1;
        sync   = 1'b0;
        enable = 3'b000;
        speed  = spd;
        tick(3);
        rst = 1'b0;
    endtask

    // Number of clocks out of n that led_out[ch] is high.
    task automatic count_high(input int ch, input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            tick(1);
            if (led_out[ch]) c++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        sync   = 1'b0;
        enable = 3'b000;
        speed  = '0;

        // Reset state
        applyStimulus(15'd0);
        checkOutput("rst_led", led_out, 3'b000);
        checkOutput("rst_lvl0", dut.level[0], 0);
        checkOutput("rst_lvl1", dut.level[1], 15);
        checkOutput("rst_lvl2", dut.level[2], 0);
        checkOutput("rst_ph0", dut.phase[0], 0);
        checkOutput("rst_ph1", dut.phase[1], 1);
        checkOutput("rst_ph2", dut.phase[2], 3);
        checkOutput("rst_pwm", dut.pwm_cnt, 0);

        // Full envelope at speed 0
        enable = 3'b001;
        tick(15);
        checkOutput("up15_lvl", dut.level[0], 15);
        checkOutput("up15_ph", dut.phase[0], 0);
        tick(1);
        checkOutput("s16_ph", dut.phase[0], 1);
        tick(3);
        checkOutput("s19_ph", dut.phase[0], 1);
        tick(1);
        checkOutput("s20_ph", dut.phase[0], 2);
        tick(16);
        checkOutput("s36_ph", dut.phase[0], 3);
        checkOutput("s36_lvl", dut.level[0], 0);
        tick(4);
        checkOutput("s40_ph", dut.phase[0], 0);

        // Speed 2: one step every 3 clocks, full cycle in 120 clocks
        applyStimulus(15'd2);
        enable = 3'b001;
        tick(47);
        checkOutput("sp2_47_ph", dut.phase[0], 0);
        checkOutput("sp2_47_lvl", dut.level[0], 15);
        tick(1);
        checkOutput("sp2_48_ph", dut.phase[0], 1);
        tick(71);
        checkOutput("sp2_119_ph", dut.phase[0], 3);
        tick(1);
        checkOutput("sp2_120_ph", dut.phase[0], 0);
        checkOutput("sp2_120_lvl", dut.level[0], 0);

        // Duty at level 15 on ch1 (HIGH), slow speed
        applyStimulus({5'd0, 5'd31, 5'd0});
        enable = 3'b010;
        tick(2);
        count_high(1, 16, cnt);
`ifdef RGBLED_CYCLE_GAMMA_EN
        checkOutput("duty15", cnt, 14);
`else
        checkOutput("duty15", cnt, 15);
`endif
        count_high(0, 16, cnt);
        checkOutput("duty_off0", cnt, 0);

        // Duty at level 8 on ch0
        applyStimulus(15'd0);
        enable = 3'b001;
        tick(8);
        checkOutput("lvl8", dut.level[0], 8);
        speed = 15'd31;
        tick(2);
        count_high(0, 16, cnt);
`ifdef RGBLED_CYCLE_GAMMA_EN
        checkOutput("duty8", cnt, 4);
`else
        checkOutput("duty8", cnt, 8);
`endif

        // Enable drop at level 7 freezes the channel
        applyStimulus(15'd0);
        enable = 3'b001;
        tick(7);
        checkOutput("frz_lvl7", dut.level[0], 7);
        enable = 3'b000;
        tick(1);
        checkOutput("frz_led", led_out[0], 1'b0);
        count_high(0, 49, cnt);
        checkOutput("frz_cnt", cnt, 0);
        checkOutput("frz_lvl", dut.level[0], 7);
        enable = 3'b001;
        tick(1);
        checkOutput("resume_lvl", dut.level[0], 8);

        // Sync mid-run with a simultaneous enable drop on ch2
        applyStimulus(15'd0);
        enable = 3'b111;
        tick(10);
        checkOutput("pre_sync_lvl0", dut.level[0], 10);
        checkOutput("pre_sync_ph1", dut.phase[1], 2);
        checkOutput("pre_sync_lvl1", dut.level[1], 9);
        checkOutput("pre_sync_lvl2", dut.level[2], 6);
        sync   = 1'b1;
        enable = 3'b011;
        tick(1);
        sync = 1'b0;
        checkOutput("sync_led", led_out, 3'b000);
        checkOutput("sync_pwm", dut.pwm_cnt, 0);
        checkOutput("sync_lvl0", dut.level[0], 0);
        checkOutput("sync_lvl1", dut.level[1], 15);
        checkOutput("sync_ph1", dut.phase[1], 1);
        checkOutput("sync_ph2", dut.phase[2], 3);
        tick(5);
        checkOutput("post_sync_lvl0", dut.level[0], 5);
        checkOutput("post_sync_lvl1", dut.level[1], 14);
        checkOutput("post_sync_lvl2", dut.level[2], 0);
        checkOutput("post_sync_led2", led_out[2], 1'b0);

        // Speed lowered below the running divider
        applyStimulus(15'd31);
        enable = 3'b001;
        tick(20);
        checkOutput("div20", dut.div[0], 20);
        checkOutput("div20_lvl", dut.level[0], 0);
        speed = 15'd0;
        tick(1);
        checkOutput("drop_div", dut.div[0], 0);
        checkOutput("drop_lvl", dut.level[0], 1);
        tick(1);
        checkOutput("drop_lvl_next", dut.level[0], 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
